conv_rd_sched: RTL and testbench

- Read scheduler for the 28-bank feature RAM that the downsample stage fills.
- On a frame-ready pulse it sweeps every convolution row and every column address, and drives the bank read address and the row-select.
- Emits column-valid/window-valid strobes aligned to RAM read latency so the 5x5 conv engine can shift columns in.
- Sits between the feature RAM and the conv MAC array; gates issue with a downstream ready.

---
 rtl/conv_rd_sched.sv | 189 ++++++++++++++++++
 tb/tb_conv_rd_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : conv_rd_sched
// Description : Read scheduler for the feature RAM feeding the 5x5 conv engine.
//               Sweeps rows/columns on a frame start, tags each issue and
//               realigns the tags with RAM read data. Optional macro
//               CONV_START_QUEUE_EN queues one start that arrives while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_rd_sched #(
    parameter int COL_NUM = 28,
    parameter int ROW_NUM = 24,
    parameter int KERNEL  = 5,
    parameter int RD_LAT  = 1
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       cal_start,
    input  logic       cal_ready,
    output logic [4:0] data_rd_addr,
    output logic [4:0] conv_row_cnt,
    output logic       col_vld,
    output logic       col_first,
    output logic       win_vld,
    output logic       row_end,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] c_COL_LAST   = 5'(COL_NUM - 1);
    localparam logic [4:0] c_ROW_LAST   = 5'(ROW_NUM - 1);
    localparam logic [4:0] c_WIN_FIRST  = 5'(KERNEL - 1);
    localparam logic [1:0] c_DRAIN_LAST = 2'(RD_LAT - 1);
    localparam int         TAG_W        = 9;

    state_t           r_state;
    logic [4:0]       r_col;
    logic [4:0]       r_row;
    logic [1:0]       r_drain_cnt;
    logic             r_busy;
    logic             r_frame_done;
    logic [4:0]       r_row_hold;
    logic             w_issue;
    logic             w_requeue;
    logic [TAG_W-1:0] w_tag_in;
    logic [TAG_W-1:0] w_tag_out;

`ifdef CONV_START_QUEUE_EN
    logic r_pending;

    // One-deep start queue; DONE consumes it (or a start landing in DONE itself).
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_pending <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_pending <= 1'b0;
        end else if (cal_start && (r_state != S_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    assign w_requeue = r_pending | cal_start;
`else
    assign w_requeue = 1'b0;
`endif

    assign w_issue = (r_state == S_RUN) && cal_ready;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= 5'd0;
            r_row        <= 5'd0;
            r_drain_cnt  <= 2'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cal_start) begin
                        r_state <= S_RUN;
                        r_col   <= 5'd0;
                        r_row   <= 5'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (r_col == c_COL_LAST) begin
                            r_col <= 5'd0;
                            if (r_row == c_ROW_LAST) begin
                                r_row       <= 5'd0;
                                r_drain_cnt <= 2'd0;
                                r_state     <= S_DRAIN;
                            end else begin
                                r_row <= r_row + 5'd1;
                            end
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last issue needs RD_LAT cycles to leave the tag pipe.
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    if (w_requeue) begin
                        r_state <= S_RUN;
                        r_col   <= 5'd0;
                        r_row   <= 5'd0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_tag_in = w_issue ? {1'b1, r_row, (r_col == 5'd0), (r_col >= c_WIN_FIRST),
                                 (r_col == c_COL_LAST)}
                              : '0;

    generate
        if (RD_LAT == 1) begin : g_pipe_one
            logic [TAG_W-1:0] r_pipe;

            always_ff @(posedge sclk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_tag_in;
                end
            end

            assign w_tag_out = r_pipe;
        end else begin : g_pipe_multi
            logic [RD_LAT*TAG_W-1:0] r_pipe;

            always_ff @(posedge sclk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[(RD_LAT-1)*TAG_W-1:0], w_tag_in};
                end
            end

            assign w_tag_out = r_pipe[RD_LAT*TAG_W-1 -: TAG_W];
        end
    endgenerate

    // Row select keeps its last value between columns so the bank mux stays put.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_row_hold <= 5'd0;
        end else if (w_tag_out[8]) begin
            r_row_hold <= w_tag_out[7:3];
        end
    end

    assign data_rd_addr = r_col;
    assign col_vld      = w_tag_out[8];
    assign conv_row_cnt = w_tag_out[8] ? w_tag_out[7:3] : r_row_hold;
    assign col_first    = w_tag_out[2];
    assign win_vld      = w_tag_out[1];
    assign row_end      = w_tag_out[0];
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_rd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_rd_sched
// Description : Directed bench for conv_rd_sched with an issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_rd_sched;

    localparam int COL_NUM = 28;
    localparam int ROW_NUM = 24;
    localparam int KERNEL  = 5;
    localparam int RD_LAT  = 1;
    localparam int FRAME   = COL_NUM * ROW_NUM;
`ifdef CONV_START_QUEUE_EN
    localparam int EXP_FRAMES_T3 = 2;
    localparam bit QEN           = 1'b1;
`else
    localparam int EXP_FRAMES_T3 = 1;
    localparam bit QEN           = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] row;
        logic [4:0] col;
    } iss_t;

    logic       sclk      = 1'b0;
    logic       s_rst_n   = 1'b1;
    logic       cal_start = 1'b0;
    logic       cal_ready = 1'b0;
    logic [4:0] data_rd_addr;
    logic [4:0] conv_row_cnt;
    logic       col_vld, col_first, win_vld, row_end, frame_done, busy;

    conv_rd_sched #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM),
        .KERNEL  (KERNEL),
        .RD_LAT  (RD_LAT)
    ) u_dut (
        .sclk         (sclk),
        .s_rst_n      (s_rst_n),
        .cal_start    (cal_start),
        .cal_ready    (cal_ready),
        .data_rd_addr (data_rd_addr),
        .conv_row_cnt (conv_row_cnt),
        .col_vld      (col_vld),
        .col_first    (col_first),
        .win_vld      (win_vld),
        .row_end      (row_end),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge sclk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard state
    iss_t       q[$];
    int         m_phase = 0;
    int         m_done_cyc = 0;
    int         m_col = 0;
    int         m_row = 0;
    bit         m_pend = 1'b0;
    logic [4:0] m_hold = 5'd0;
    int n_vld = 0, n_first = 0, n_win = 0, n_end = 0, n_busy = 0, n_done = 0, n_iss = 0;
    int first_vld_cyc = 0, last_vld_cyc = 0, done_cyc = 0;

    always @(negedge sclk) begin : p_mon
        iss_t e;
        bit   done_now;
        bit   iss;
        if (!s_rst_n) begin
            m_phase = 0;
            m_pend  = 1'b0;
            m_col   = 0;
            m_row   = 0;
            m_hold  = 5'd0;
            q.delete();
        end else begin
            done_now = (m_phase == 2) && (cyc == m_done_cyc);
            chk("busy", busy, m_phase != 0);
            chk("frame_done", frame_done, done_now);
            chk("rd_addr", data_rd_addr, m_col);
            if (busy) n_busy++;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (col_vld) begin
                if (q.size() == 0) begin
                    chk("vld_unexpected", col_vld, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("vld_latency", cyc, e.cyc + RD_LAT);
                    chk("row_sel", conv_row_cnt, e.row);
                    chk("col_first", col_first, e.col == 5'd0);
                    chk("win_vld", win_vld, e.col >= KERNEL - 1);
                    chk("row_end", row_end, e.col == COL_NUM - 1);
                    m_hold = e.row;
                    if (e.row == 0 && e.col == 0) first_vld_cyc = cyc;
                    if (e.row == ROW_NUM - 1 && e.col == COL_NUM - 1) last_vld_cyc = cyc;
                end
                n_vld++;
                if (col_first) n_first++;
                if (win_vld) n_win++;
                if (row_end) n_end++;
            end else begin
                chk("row_hold", conv_row_cnt, m_hold);
                chk("idle_flags", {col_first, win_vld, row_end}, 3'b000);
                if (q.size() > 0 && q[0].cyc + RD_LAT <= cyc) begin
                    chk("vld_missing", col_vld, 1'b1);
                    q.delete(0);
                end
            end

            if (QEN && cal_start && m_phase != 0 && !done_now) m_pend = 1'b1;
            iss = (m_phase == 1) && cal_ready;
            if (iss) begin
                e.cyc = cyc;
                e.row = 5'(m_row);
                e.col = 5'(m_col);
                q.push_back(e);
                n_iss++;
                if (m_col == COL_NUM - 1) begin
                    m_col = 0;
                    if (m_row == ROW_NUM - 1) begin
                        m_row      = 0;
                        m_phase    = 2;
                        m_done_cyc = cyc + RD_LAT + 1;
                    end else begin
                        m_row++;
                    end
                end else begin
                    m_col++;
                end
            end else if (done_now) begin
                m_phase = (QEN && (m_pend || cal_start)) ? 1 : 0;
                m_pend  = 1'b0;
            end else if (m_phase == 0 && cal_start) begin
                m_phase = 1;
            end
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic pulse_start();
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            step();
            k++;
        end
        chk("done_timeout", n_done >= target, 1'b1);
    endtask

    task automatic wait_pos(input int r, input int c, input int budget);
        int k = 0;
        while (!(m_row == r && m_col == c) && k < budget) begin
            step();
            k++;
        end
        chk("pos_timeout", (m_row == r && m_col == c), 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {data_rd_addr, conv_row_cnt, col_vld, col_first, win_vld, row_end,
                  frame_done, busy}, 16'd0);
    endtask

    initial begin
        int s, b_vld, b_first, b_win, b_end, b_busy, b_done, b_iss, k;

        // Reset state
        #1 s_rst_n = 1'b0;
        #1 chk_zero("reset_state");
        repeat (3) step();
        s_rst_n = 1'b1;
        repeat (2) step();

        // Full frame with cal_ready held high
        b_vld = n_vld; b_first = n_first; b_win = n_win; b_end = n_end;
        b_busy = n_busy; b_done = n_done;
        cal_ready = 1'b1;
        s = cyc;
        pulse_start();
        wait_done(b_done + 1, 3 * FRAME);
        repeat (3) step();
        chk("t1_first_vld_cyc", first_vld_cyc, s + 1 + RD_LAT);
        chk("t1_gapless", last_vld_cyc - first_vld_cyc + 1, FRAME);
        chk("t1_done_after_last", done_cyc, last_vld_cyc + 1);
        chk("t1_vld_cnt", n_vld - b_vld, FRAME);
        chk("t1_first_cnt", n_first - b_first, ROW_NUM);
        chk("t1_end_cnt", n_end - b_end, ROW_NUM);
        chk("t1_win_cnt", n_win - b_win, ROW_NUM * (COL_NUM - KERNEL + 1));
        chk("t1_busy_cycles", n_busy - b_busy, FRAME + RD_LAT + 1);

        // cal_ready toggling every cycle
        b_vld = n_vld; b_iss = n_iss; b_done = n_done;
        pulse_start();
        k = 0;
        while (n_done < b_done + 1 && k < 4 * FRAME) begin
            cal_ready = ~cal_ready;
            step();
            k++;
        end
        chk("t2_done_timeout", n_done >= b_done + 1, 1'b1);
        cal_ready = 1'b1;
        repeat (3) step();
        chk("t2_vld_cnt", n_vld - b_vld, FRAME);
        chk("t2_iss_cnt", n_iss - b_iss, FRAME);

        // cal_start while busy (row 10, then again at row 15)
        b_done = n_done;
        pulse_start();
        wait_pos(10, 0, 2 * FRAME);
        pulse_start();
        wait_pos(15, 0, 2 * FRAME);
        pulse_start();
        wait_done(b_done + EXP_FRAMES_T3, 4 * FRAME);
        repeat (FRAME + 20) step();
        chk("t3_frames", n_done - b_done, EXP_FRAMES_T3);
        chk("t3_busy_low", busy, 1'b0);

        // Asynchronous reset mid-frame at row 5, col 13
        b_done = n_done;
        pulse_start();
        wait_pos(5, 13, 2 * FRAME);
        #2 s_rst_n = 1'b0;
        #1 chk_zero("t4_async_reset");
        repeat (3) step();
        s_rst_n = 1'b1;
        repeat (2) step();
        chk("t4_no_done", n_done - b_done, 0);

        // Restart, then drop cal_ready for 10 cycles mid-frame
        b_vld = n_vld; b_done = n_done;
        pulse_start();
        wait_pos(2, 0, 2 * FRAME);
        cal_ready = 1'b0;
        k = n_vld;
        repeat (10) step();
        chk("t4_inflight_vld", n_vld - k, RD_LAT);
        cal_ready = 1'b1;
        wait_done(b_done + 1, 3 * FRAME);
        repeat (3) step();
        chk("t4_vld_cnt", n_vld - b_vld, FRAME);
        chk("t4_idle_after", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
